// File: rtl/led_bar_pkg.sv
// Shared types and defaults for the LED fill-bar scheduler.
package led_bar_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } bar_state_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: a one-cycle tick every TICK_DIV cycles while enabled.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..TICK_DIV-1 while enabled; hold at zero when disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!en || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/led_bar_scheduler.sv
// LED fill-bar scheduler: arbitrates manual and auto-sweep step requests
// onto a single saturating level register driving a thermometer bar.
module led_bar_scheduler
  import led_bar_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEFAULT,
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       man_fill,
  input  logic                       man_drain,
  input  logic                       auto_en,
  output logic [WIDTH-1:0]           LED,
  output logic [$clog2(WIDTH+1)-1:0] level,
  output logic                       grant_man,
  output logic                       grant_auto,
  output logic                       reject
);

  localparam int unsigned LW = $clog2(WIDTH + 1);
  localparam logic [LW-1:0] MAX_LVL = LW'(WIDTH);

  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_led;
  bar_state_t       r_st;
  dir_t             r_dir;
  logic             r_pend;
  logic             r_grant_man;
  logic             r_grant_auto;
  logic             r_reject;

  logic             w_tick;
  logic             w_man_one;
  logic             w_auto_req;
  logic             w_auto_take;
  logic             w_take;
  logic             w_fill;
  logic             w_legal;
  logic [LW-1:0]    w_level_nxt;
  bar_state_t       w_st_nxt;
  dir_t             w_dir_nxt;
  logic [WIDTH-1:0] w_led_nxt;
  logic             w_pend_nxt;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (auto_en),
    .tick (w_tick)
  );

  // Arbitration, legality and next-state computation.
  always_comb begin
    w_man_one   = man_fill ^ man_drain;
    w_auto_req  = auto_en & (r_pend | w_tick);
    w_auto_take = w_auto_req & ~w_man_one;
    w_take      = w_man_one | w_auto_req;
    w_fill      = w_man_one ? man_fill : (r_dir == UP);
    w_legal     = w_fill ? (r_st != FULL) : (r_st != EMPTY);

    w_level_nxt = r_level;
    if (w_take && w_legal) begin
      w_level_nxt = w_fill ? (r_level + 1'b1) : (r_level - 1'b1);
    end

    if (w_level_nxt == '0) begin
      w_st_nxt = EMPTY;
    end else if (w_level_nxt == MAX_LVL) begin
      w_st_nxt = FULL;
    end else begin
      w_st_nxt = PARTIAL;
    end

    w_dir_nxt = r_dir;
    if (w_take && w_legal) begin
      if (w_st_nxt == FULL) begin
        w_dir_nxt = DOWN;
      end else if (w_st_nxt == EMPTY) begin
        w_dir_nxt = UP;
      end
    end

    w_led_nxt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_led_nxt[i] = ((i + 32'(w_level_nxt)) >= WIDTH);
    end

    // A taken auto request clears pend even when rejected.
    if (!auto_en || w_auto_take) begin
      w_pend_nxt = 1'b0;
    end else if (w_tick) begin
      w_pend_nxt = 1'b1;
    end else begin
      w_pend_nxt = r_pend;
    end
  end

  // Bar state, direction, pending auto request and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level      <= '0;
      r_led        <= '0;
      r_st         <= EMPTY;
      r_dir        <= UP;
      r_pend       <= 1'b0;
      r_grant_man  <= 1'b0;
      r_grant_auto <= 1'b0;
      r_reject     <= 1'b0;
    end else begin
      r_level      <= w_level_nxt;
      r_led        <= w_led_nxt;
      r_st         <= w_st_nxt;
      r_dir        <= w_dir_nxt;
      r_pend       <= w_pend_nxt;
      r_grant_man  <= w_man_one & w_legal;
      r_grant_auto <= w_auto_take & w_legal;
      r_reject     <= w_take & ~w_legal;
    end
  end

  assign LED        = r_led;
  assign level      = r_level;
  assign grant_man  = r_grant_man;
  assign grant_auto = r_grant_auto;
  assign reject     = r_reject;

endmodule

// File: tb/tb_led_bar_scheduler.sv
// Self-checking bench for led_bar_scheduler (WIDTH=16, TICK_DIV=4).
module tb_led_bar_scheduler;
  import led_bar_pkg::*;

  localparam int W  = 16;
  localparam int TD = 4;

  logic        clk;
  logic        rst;
  logic        man_fill;
  logic        man_drain;
  logic        auto_en;
  logic [15:0] LED;
  logic [4:0]  level;
  logic        grant_man;
  logic        grant_auto;
  logic        reject;

  logic [23:0] obs;
  assign obs = {LED, level, grant_man, grant_auto, reject};

  int checks   = 0;
  int failures = 0;

  logic [23:0] exp_q[$];

  int m_level;
  int m_cnt;
  bit m_dir;
  bit m_pend;

  led_bar_scheduler #(
    .WIDTH    (W),
    .TICK_DIV (TD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .man_fill   (man_fill),
    .man_drain  (man_drain),
    .auto_en    (auto_en),
    .LED        (LED),
    .level      (level),
    .grant_man  (grant_man),
    .grant_auto (grant_auto),
    .reject     (reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] led_of(input int lv);
    logic [15:0] ones;
    ones = 16'hFFFF;
    if (lv == 0) return 16'h0000;
    return ones << (16 - lv);
  endfunction

  task automatic model_reset();
    m_level = 0;
    m_cnt   = 0;
    m_dir   = 1'b0;
    m_pend  = 1'b0;
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus, predict the outcome, push it, clock the DUT.
  task automatic drive(input logic f, input logic d, input logic a);
    bit   tick, areq, man, fill, ok;
    logic gm, ga, rj;
    @(negedge clk);
    man_fill  = f;
    man_drain = d;
    auto_en   = a;
    tick = a && (m_cnt == TD - 1);
    areq = a && (m_pend || tick);
    man  = f ^ d;
    gm = 1'b0; ga = 1'b0; rj = 1'b0;
    if (man || areq) begin
      fill = man ? f : (m_dir == 1'b0);
      ok   = fill ? (m_level < W) : (m_level > 0);
      if (ok) begin
        m_level = m_level + (fill ? 1 : -1);
        if (m_level == W) m_dir = 1'b1;
        if (m_level == 0) m_dir = 1'b0;
        if (man) gm = 1'b1; else ga = 1'b1;
      end else begin
        rj = 1'b1;
      end
    end
    if (!a) m_pend = 1'b0;
    else if (areq && !man) m_pend = 1'b0;
    else if (tick) m_pend = 1'b1;
    m_cnt = !a ? 0 : ((m_cnt == TD - 1) ? 0 : m_cnt + 1);
    exp_q.push_back({led_of(m_level), 5'(m_level), gm, ga, rj});
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst       = 1'b0;
    man_fill  = 1'b0;
    man_drain = 1'b0;
    auto_en   = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    man_fill = 1'b0; man_drain = 1'b0; auto_en = 1'b0;
    rst = 1'b0;
    model_reset();
    #12;
    checks++;
    if (obs !== 24'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 24'h0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fill_to_full();
    logic [23:0] e;
    apply_reset();
    for (int k = 1; k <= 17; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL fill_step%0d: got %h expected %h", k, obs, e);
      end
      if (k == 16) begin
        checks++;
        if (LED !== 16'hFFFF || dut.r_st !== FULL) begin
          failures++;
          $display("FAIL full_reached: got LED=%h st=%0d expected LED=ffff st=%0d",
                   LED, dut.r_st, FULL);
        end
      end
      if (k == 17) begin
        checks++;
        if (reject !== 1'b1 || LED !== 16'hFFFF || grant_man !== 1'b0) begin
          failures++;
          $display("FAIL fill_at_full: got rej=%b LED=%h gm=%b expected rej=1 LED=ffff gm=0",
                   reject, LED, grant_man);
        end
      end
      for (int g = 0; g < 2; g++) begin
        drive(1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL fill_gap%0d: got %h expected %h", k, obs, e);
        end
      end
    end
  endtask

  task automatic test_drain_empty_cancel();
    logic [23:0] e;
    apply_reset();
    drive(1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e || reject !== 1'b1 || level !== 5'd0) begin
      failures++;
      $display("FAIL drain_at_empty: got %h expected %h", obs, e);
    end
    drive(1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e || {grant_man, grant_auto, reject} !== 3'b000) begin
      failures++;
      $display("FAIL cancel: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_auto_sweep();
    logic [23:0] e;
    apply_reset();
    for (int c = 0; c < 140; c++) begin
      drive(1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL sweep_c%0d: got %h expected %h", c, obs, e);
      end
      if (c == 63 || c == 127 || c == 131) begin
        checks++;
        if (grant_auto !== 1'b1 ||
            level !== ((c == 63) ? 5'd16 : (c == 127) ? 5'd0 : 5'd1)) begin
          failures++;
          $display("FAIL sweep_turn_c%0d: got ga=%b level=%0d", c, grant_auto, level);
        end
      end
    end
  endtask

  task automatic test_coincident();
    logic [23:0] e;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL coin_prefill%0d: got %h expected %h", k, obs, e);
      end
    end
    for (int k = 0; k < 5; k++) begin
      drive((k == 3) ? 1'b1 : 1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL coin_c%0d: got %h expected %h", k, obs, e);
      end
    end
    checks++;
    if (grant_auto !== 1'b1 || level !== 5'd7) begin
      failures++;
      $display("FAIL coin_deferred_auto: got ga=%b level=%0d expected ga=1 level=7",
               grant_auto, level);
    end
  endtask

  task automatic test_auto_disable();
    logic [23:0] e;
    logic a;
    for (int k = 0; k < 8; k++) begin
      a = (k == 3) ? 1'b0 : 1'b1;
      drive((k == 2) ? 1'b1 : 1'b0, 1'b0, a);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL disable_c%0d: got %h expected %h", k, obs, e);
      end
      if (k == 3) begin
        checks++;
        if (grant_auto !== 1'b0 || level !== 5'd8) begin
          failures++;
          $display("FAIL disable_drop: got ga=%b level=%0d expected ga=0 level=8",
                   grant_auto, level);
        end
      end
    end
    checks++;
    if (grant_auto !== 1'b1 || level !== 5'd9) begin
      failures++;
      $display("FAIL disable_reenable: got ga=%b level=%0d expected ga=1 level=9",
               grant_auto, level);
    end
  endtask

  task automatic test_async_reset();
    logic [23:0] e;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL pre_reset%0d: got %h expected %h", k, obs, e);
      end
    end
    @(negedge clk);
    #2;
    rst     = 1'b0;
    auto_en = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== 24'h0) begin
      failures++;
      $display("FAIL async_reset: got %h expected %h", obs, 24'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (dut.r_dir !== UP) begin
      failures++;
      $display("FAIL dir_after_reset: got %0d expected %0d", dut.r_dir, UP);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL post_reset%0d: got %h expected %h", k, obs, e);
      end
    end
    checks++;
    if (grant_auto !== 1'b1 || level !== 5'd1) begin
      failures++;
      $display("FAIL post_reset_up: got ga=%b level=%0d expected ga=1 level=1",
               grant_auto, level);
    end
  endtask

  initial begin
    test_reset();
    test_fill_to_full();
    test_drain_empty_cancel();
    test_auto_sweep();
    test_coincident();
    test_auto_disable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
